jamma_joy_demux: RTL

Upstream input stage for the arcade cores on the ZX-UNO/JAMMA board. It drives the JAMMA joystick select line and demultiplexes the shared 8-bit JJOY bus into per-player words. Each bit and each coin line is debounced, and the keyboard/DB9 joystick is merged into player 1. Its outputs feed the core's I_JOYSTICK_A/B, I_PLAYER and I_COIN inputs directly, replacing the free-running per-cycle select toggle.

---
 rtl/jamma_joy_demux.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/jamma_joy_demux.sv
// JAMMA joystick bus demux with per-bit debounce and keyboard merge into P1.
// Define JAMMA_SOCD_EN to release opposing directions pressed together.
module jamma_joy_demux #(
   parameter int SETTLE_CYC = 8,
   parameter int DEB_BITS   = 4
) (
   input  logic       pclk,
   input  logic       rst_n,
   input  logic [7:0] JJOY,
   input  logic [1:0] JCOIN,
   input  logic [5:0] kbd_joy,
   output logic       JSELECT,
   output logic [7:0] joystick1,
   output logic [7:0] joystick2,
   output logic [1:0] coin,
   output logic       joy_valid
);

   typedef enum logic [1:0] {
      P1_SETTLE,
      P1_SAMPLE,
      P2_SETTLE,
      P2_SAMPLE
   } state_t;

   localparam logic [7:0] SET_LAST = 8'(SETTLE_CYC - 1);
   localparam logic [DEB_BITS-1:0] DEB_MAX = '1;

   state_t     st, st_nxt;
   logic [7:0] set_cnt, set_nxt;
   logic       jsel_nxt;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= P1_SETTLE;
         set_cnt <= '0;
         JSELECT <= 1'b0;
      end else begin
         st      <= st_nxt;
         set_cnt <= set_nxt;
         JSELECT <= jsel_nxt;
      end
   end

   always_comb begin
      st_nxt   = st;
      set_nxt  = set_cnt;
      jsel_nxt = JSELECT;
      unique case (st)
         P1_SETTLE, P2_SETTLE: begin
            if (set_cnt == SET_LAST) begin
               st_nxt  = (st == P1_SETTLE) ? P1_SAMPLE : P2_SAMPLE;
               set_nxt = '0;
            end else begin
               set_nxt = set_cnt + 8'd1;
            end
         end
         P1_SAMPLE: begin
            st_nxt   = P2_SETTLE;
            jsel_nxt = 1'b1;
         end
         P2_SAMPLE: begin
            st_nxt   = P1_SETTLE;
            jsel_nxt = 1'b0;
         end
         default: st_nxt = P1_SETTLE;
      endcase
   end

   // Coins are not multiplexed, so they are synchronised before sampling
   logic [1:0] coin_s1, coin_s2;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         coin_s1 <= 2'b11;
         coin_s2 <= 2'b11;
      end else begin
         coin_s1 <= JCOIN;
         coin_s2 <= coin_s1;
      end
   end

   logic        samp_p1, samp_p2;
   logic [17:0] deb_din, deb_en, deb_q;

   assign samp_p1 = (st == P1_SAMPLE);
   assign samp_p2 = (st == P2_SAMPLE);
   assign deb_din = {coin_s2, JJOY, JJOY};
   assign deb_en  = {{2{samp_p1 | samp_p2}}, {8{samp_p2}}, {8{samp_p1}}};

   for (genvar i = 0; i < 18; i++) begin : g_deb
      logic                q;
      logic [DEB_BITS-1:0] c;

      always_ff @(posedge pclk or negedge rst_n) begin
         if (!rst_n) begin
            q <= 1'b1;
            c <= '0;
         end else if (deb_en[i]) begin
            if (deb_din[i] == q) begin
               c <= '0;
            end else if (c == DEB_MAX) begin
               q <= ~q;
               c <= '0;
            end else begin
               c <= c + DEB_BITS'(1);
            end
         end
      end

      assign deb_q[i] = q;
   end

   function automatic logic [7:0] socd(input logic [7:0] w);
      logic [7:0] r;
      r = w;
`ifdef JAMMA_SOCD_EN
      if (!w[0] && !w[1]) r[1:0] = 2'b11;
      if (!w[2] && !w[3]) r[3:2] = 2'b11;
`else
      r = w;
`endif
      return r;
   endfunction

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         joystick1 <= 8'hFF;
         joystick2 <= 8'hFF;
         coin      <= 2'b11;
         joy_valid <= 1'b0;
      end else begin
         joystick1 <= socd({deb_q[7:6], deb_q[5:0] & kbd_joy});
         joystick2 <= socd(deb_q[15:8]);
         coin      <= deb_q[17:16];
         joy_valid <= joy_valid | samp_p2;
      end
   end

endmodule
